// File: rtl/spi_master_scheduler_pkg.sv
// spi_sched_pkg: shared types and constants for the SPI master scheduler.
// Provides the scheduler state enum, default widths and the owner index width helper.
// Optional build macro used by the scheduler: SPI_SCHED_TIMEOUT_EN.
package spi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOAD = 2'd2,
    DRAIN     = 2'd3
  } state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_DATAW = 16;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_scheduler_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin winner search.
// Ports: req_i request vector, ptr_i search start; any_o some request present,
//        win_o first requester at or after ptr_i (cyclic). Zero latency, no state.
module spi_rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            any_o,
  output logic [IW-1:0]   win_o
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;

  // Rotate so that bit 0 of req_rot is the requester at ptr_i.
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[ptr_i +: NREQ];
  assign any_o   = |req_i;

  always_comb begin
    off = '0;
    // Descending scan: the smallest offset from ptr_i is written last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off = IW'(k);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW+1)'(NREQ)) begin
      win_o = IW'(sum - (IW+1)'(NREQ));
    end else begin
      win_o = sum[IW-1:0];
    end
  end

endmodule

// File: rtl/spi_master_scheduler.sv
// spi_master_scheduler: shares one SPI master between NREQ requesters, one packet per grant.
// Ports: req_* requester word streams, rsp_* routed responses, m_* master handshake,
//        err_* sticky flags (err_clr clears), busy/grant_id status.
// Build macro SPI_SCHED_TIMEOUT_EN adds a watchdog that aborts a stuck grant after TIMEOUT_CYC cycles.
module spi_master_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int DATAW       = DEF_DATAW,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DATAW-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [DATAW-1:0]        rsp_data,
  output logic                    rsp_last,
  output logic [DATAW-1:0]        m_tData,
  output logic                    m_requestInsert,
  input  logic                    m_doneInsert,
  input  logic [DATAW-1:0]        m_rData,
  input  logic                    m_requestReceived,
  output logic                    m_doneSaved,
  input  logic                    m_overflowT,
  input  logic                    m_overflowR,
  input  logic                    err_clr,
  output logic                    busy,
  output logic [idx_w(NREQ)-1:0]  grant_id,
  output logic                    err_overflow,
  output logic                    err_spurious,
  output logic                    err_timeout
);

  localparam int IW = idx_w(NREQ);

  if (NREQ < 2 || NREQ > 8 || DATAW < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("spi_master_scheduler: parameter out of range");
  end

  state_e              state_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [1:0]          outstanding_q;
  logic [1:0]          outstanding_d;
  logic [DATAW-1:0]    tx_hold_q;
  logic                last_q;
  logic [NREQ-1:0]     req_ready_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic [DATAW-1:0]    rsp_data_q;
  logic                rsp_last_q;
  logic                m_requestInsert_q;
  logic                m_doneSaved_q;
  logic                err_overflow_q;
  logic                err_spurious_q;

  logic                arb_any;
  logic [IW-1:0]       arb_win;
  logic [IW-1:0]       owner_next;
  logic [NREQ-1:0]     owner_oh;
  logic                sel_valid;
  logic                sel_last;
  logic [DATAW-1:0]    sel_data;
  logic                do_inc;
  logic                do_dec;

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (arb_any),
    .win_o (arb_win)
  );

  // Owner decode and per-owner request mux.
  always_comb begin
    owner_oh  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == IW'(k)) begin
        owner_oh[k] = 1'b1;
        sel_valid   = req_valid[k];
        sel_last    = req_last[k];
        sel_data    = req_data[k*DATAW +: DATAW];
      end
    end
  end

  assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  // Words in flight: +1 on issue, -1 on each response, saturating both ways.
  assign do_inc = (state_q == ISSUE) && sel_valid;
  assign do_dec = m_requestReceived && (state_q != IDLE);

  always_comb begin
    outstanding_d = outstanding_q;
    if (do_inc && !do_dec && outstanding_q != 2'd3) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (do_dec && !do_inc && outstanding_q != 2'd0) begin
      outstanding_d = outstanding_q - 2'd1;
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_q;
  logic           wd_run;
  logic           wd_clr;
  logic           wd_fire;
  logic           err_timeout_q;

  // Counter restarts whenever the FSM leaves or changes its waiting state, or a response arrives.
  assign wd_run  = (state_q == WAIT_LOAD) || (state_q == DRAIN);
  assign wd_clr  = !wd_run || m_requestReceived ||
                   ((state_q == WAIT_LOAD) && m_doneInsert) ||
                   ((state_q == DRAIN) && (outstanding_q == 2'd0));
  assign wd_fire = !wd_clr && (wd_q == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wd_q          <= (wd_clr || wd_fire) ? '0 : wd_q + WDW'(1);
      err_timeout_q <= (err_timeout_q && !err_clr) || wd_fire;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      owner_q           <= '0;
      rr_ptr_q          <= '0;
      outstanding_q     <= '0;
      tx_hold_q         <= '0;
      last_q            <= 1'b0;
      req_ready_q       <= '0;
      rsp_valid_q       <= '0;
      rsp_data_q        <= '0;
      rsp_last_q        <= 1'b0;
      m_requestInsert_q <= 1'b0;
      m_doneSaved_q     <= 1'b0;
      err_overflow_q    <= 1'b0;
      err_spurious_q    <= 1'b0;
    end else begin
      req_ready_q       <= '0;
      rsp_valid_q       <= '0;
      rsp_last_q        <= 1'b0;
      m_requestInsert_q <= 1'b0;
      m_doneSaved_q     <= 1'b0;
      outstanding_q     <= outstanding_d;

      // Set beats clear when both happen in the same cycle.
      err_overflow_q <= (err_overflow_q && !err_clr) || m_overflowT || m_overflowR;
      err_spurious_q <= (err_spurious_q && !err_clr) ||
                        (m_requestReceived && (state_q == IDLE));

      // Every received word is acknowledged; only words inside a grant are routed.
      if (m_requestReceived) begin
        m_doneSaved_q <= 1'b1;
        if (state_q != IDLE) begin
          rsp_valid_q <= owner_oh;
          rsp_data_q  <= m_rData;
          rsp_last_q  <= last_q && (outstanding_q == 2'd1);
        end
      end

      case (state_q)
        IDLE: begin
          if (arb_any) begin
            owner_q <= arb_win;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (sel_valid) begin
            tx_hold_q         <= sel_data;
            last_q            <= sel_last;
            req_ready_q       <= owner_oh;
            m_requestInsert_q <= 1'b1;
            state_q           <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          if (m_doneInsert) begin
            state_q <= last_q ? DRAIN : ISSUE;
          end
        end
        DRAIN: begin
          if (outstanding_q == 2'd0) begin
            rr_ptr_q <= owner_next;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef SPI_SCHED_TIMEOUT_EN
      // Abort the grant: forget in-flight words and pass the turn on.
      if (wd_fire) begin
        outstanding_q <= '0;
        rr_ptr_q      <= owner_next;
        state_q       <= IDLE;
      end
`endif
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_last        = rsp_last_q;
  assign m_tData         = tx_hold_q;
  assign m_requestInsert = m_requestInsert_q;
  assign m_doneSaved     = m_doneSaved_q;
  assign busy            = (state_q != IDLE);
  assign grant_id        = owner_q;
  assign err_overflow    = err_overflow_q;
  assign err_spurious    = err_spurious_q;

endmodule

// File: tb/tb_spi_master_scheduler.sv
// tb_spi_master_scheduler: scenario tasks against a master model that echoes ~word.
// Expected responses are queued when a word is accepted and popped by the response monitor.
// Optional watchdog scenario runs when SPI_SCHED_TIMEOUT_EN is defined.
module tb_spi_master_scheduler;

  localparam int NREQ  = 4;
  localparam int DATAW = 16;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DATAW-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [DATAW-1:0]      rsp_data;
  logic                  rsp_last;
  logic [DATAW-1:0]      m_tData;
  logic                  m_requestInsert;
  logic                  m_doneInsert;
  logic [DATAW-1:0]      m_rData;
  logic                  m_requestReceived;
  logic                  m_doneSaved;
  logic                  m_overflowT;
  logic                  m_overflowR;
  logic                  err_clr;
  logic                  busy;
  logic [IW-1:0]         grant_id;
  logic                  err_overflow;
  logic                  err_spurious;
  logic                  err_timeout;

  logic                  mdl_rx;
  logic                  spur_rx;

  always #5 clk = ~clk;

  assign m_requestReceived = mdl_rx | spur_rx;

  spi_master_scheduler #(
    .NREQ        (NREQ),
    .DATAW       (DATAW),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_last          (rsp_last),
    .m_tData           (m_tData),
    .m_requestInsert   (m_requestInsert),
    .m_doneInsert      (m_doneInsert),
    .m_rData           (m_rData),
    .m_requestReceived (m_requestReceived),
    .m_doneSaved       (m_doneSaved),
    .m_overflowT       (m_overflowT),
    .m_overflowR       (m_overflowR),
    .err_clr           (err_clr),
    .busy              (busy),
    .grant_id          (grant_id),
    .err_overflow      (err_overflow),
    .err_spurious      (err_spurious),
    .err_timeout       (err_timeout)
  );

  typedef struct {
    logic [NREQ-1:0]  oh;
    logic [DATAW-1:0] data;
    logic             last;
  } exp_t;

  exp_t sbq[$];
  int   grant_log[$];
  int   tests  = 0;
  int   failed = 0;

  // Master model state.
  int               ins_delay  = 0;
  bit               master_en  = 1'b1;
  int               ins_cnt    = -1;
  int               rx_cnt     = -1;
  logic [DATAW-1:0] ins_word;
  logic [DATAW-1:0] rx_word;
  int               insert_cnt = 0;
  int               extra_ins  = 0;
  int               tdata_bad  = 0;
  int               ready_cnt  = 0;
  bit               busy_prev  = 1'b0;

  // Master model: loads the held word after ins_delay cycles, answers ~word two cycles later.
  always @(negedge clk) begin
    m_doneInsert = 1'b0;
    mdl_rx       = 1'b0;
    if (rst) begin
      ins_cnt = -1;
      rx_cnt  = -1;
    end else begin
      if (m_requestInsert) insert_cnt++;
      if (rx_cnt == 0) begin
        mdl_rx  = 1'b1;
        m_rData = rx_word;
        rx_cnt  = -1;
      end else if (rx_cnt > 0) begin
        rx_cnt--;
      end
      if (ins_cnt >= 0) begin
        if (m_tData !== ins_word) tdata_bad++;
        if (m_requestInsert) extra_ins++;
        if (ins_cnt == 0) begin
          m_doneInsert = 1'b1;
          rx_word      = ~ins_word;
          rx_cnt       = 1;
          ins_cnt      = -1;
        end else begin
          ins_cnt--;
        end
      end else if (m_requestInsert && master_en) begin
        ins_word = m_tData;
        ins_cnt  = ins_delay;
      end
    end
  end

  // Response monitor: every rsp_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (|req_ready) ready_cnt++;
      if (busy && !busy_prev) grant_log.push_back(int'(grant_id));
      busy_prev = busy;
      if (|rsp_valid) begin
        tests++;
        if (sbq.size() == 0) begin
          failed++;
          $display("FAIL rsp_unexpected: got valid=%b data=%h, required no response", rsp_valid, rsp_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (rsp_valid !== e.oh || rsp_data !== e.data || rsp_last !== e.last || m_doneSaved !== 1'b1) begin
            failed++;
            $display("FAIL rsp_match: got valid=%b data=%h last=%b saved=%b, required valid=%b data=%h last=%b saved=1",
                     rsp_valid, rsp_data, rsp_last, m_doneSaved, e.oh, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic send_pkt(input int id, input int n, input logic [DATAW-1:0] base,
                          input int gap_after, input int gap_len);
    for (int w = 0; w < n; w++) begin
      bit              got;
      logic [NREQ-1:0] oh;
      got = 1'b0;
      oh  = '0;
      oh[id] = 1'b1;
      req_data[id*DATAW +: DATAW] = base + DATAW'(w);
      req_last[id]  = (w == n - 1);
      req_valid[id] = 1'b1;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        if (req_ready[id]) begin
          got = 1'b1;
          break;
        end
      end
      tests++;
      if (!got || req_ready !== oh) begin
        failed++;
        $display("FAIL req_ready_%0d_w%0d: got %b, required %b", id, w, req_ready, oh);
      end
      if (got) sbq.push_back('{oh, ~(base + DATAW'(w)), (w == n - 1)});
      if (w == gap_after) begin
        req_valid[id] = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          tests++;
          if (req_ready !== '0 || busy !== 1'b1 || grant_id !== IW'(id)) begin
            failed++;
            $display("FAIL bubble_hold: got ready=%b busy=%b grant=%0d, required ready=0 busy=1 grant=%0d",
                     req_ready, busy, grant_id, id);
          end
        end
      end
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0 && ins_cnt < 0 && rx_cnt < 0) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s_idle: got busy=%b pending=%0d, required busy=0 pending=0", name, busy, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, rsp_data, rsp_last, m_tData, m_requestInsert, m_doneSaved,
         busy, grant_id, err_overflow, err_spurious, err_timeout} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got ready=%b rsp=%b tdata=%h busy=%b grant=%0d, required all 0",
               req_ready, rsp_valid, m_tData, busy, grant_id);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_packet();
    int r0;
    r0 = ready_cnt;
    send_pkt(0, 3, 16'hA001, -1, 0);
    wait_idle("single_packet");
    tests++;
    if (ready_cnt - r0 != 3) begin
      failed++;
      $display("FAIL single_ready_count: got %0d, required 3", ready_cnt - r0);
    end
  endtask

  task automatic test_round_robin();
    grant_log.delete();
    fork
      begin
        send_pkt(1, 2, 16'h1100, -1, 0);
        send_pkt(1, 2, 16'h1200, -1, 0);
      end
      send_pkt(2, 2, 16'h2200, -1, 0);
    join
    wait_idle("round_robin");
    tests++;
    if (grant_log.size() != 3 || grant_log[0] != 1 || grant_log[1] != 2 || grant_log[2] != 1) begin
      failed++;
      $display("FAIL rr_order: got %p, required '{1, 2, 1}", grant_log);
    end
  endtask

  task automatic test_slow_load();
    int i0, e0, t0;
    i0 = insert_cnt;
    e0 = extra_ins;
    t0 = tdata_bad;
    ins_delay = 20;
    send_pkt(3, 1, 16'hBEEF, -1, 0);
    @(negedge clk);
    tests++;
    if (m_tData !== 16'hBEEF) begin
      failed++;
      $display("FAIL slow_tdata: got %h, required beef", m_tData);
    end
    wait_idle("slow_load");
    ins_delay = 0;
    tests++;
    if (insert_cnt - i0 != 1 || extra_ins != e0 || tdata_bad != t0) begin
      failed++;
      $display("FAIL slow_hold: got inserts=%0d extra=%0d unstable=%0d, required 1 0 0",
               insert_cnt - i0, extra_ins - e0, tdata_bad - t0);
    end
  endtask

  task automatic test_bubble();
    grant_log.delete();
    send_pkt(0, 3, 16'h0C10, 1, 5);
    wait_idle("bubble");
    tests++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      failed++;
      $display("FAIL bubble_grants: got %p, required '{0}", grant_log);
    end
  endtask

  task automatic test_spurious();
    spur_rx = 1'b1;
    @(negedge clk);
    spur_rx = 1'b0;
    tests++;
    if (m_doneSaved !== 1'b1 || err_spurious !== 1'b1 || rsp_valid !== '0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL spurious_set: got saved=%b err=%b rsp=%b busy=%b, required 1 1 0 0",
               m_doneSaved, err_spurious, rsp_valid, busy);
    end
    @(negedge clk);
    tests++;
    if (m_doneSaved !== 1'b0 || err_spurious !== 1'b1) begin
      failed++;
      $display("FAIL spurious_sticky: got saved=%b err=%b, required 0 1", m_doneSaved, err_spurious);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (err_spurious !== 1'b0) begin
      failed++;
      $display("FAIL spurious_clear: got %b, required 0", err_spurious);
    end
  endtask

  task automatic test_overflow();
    m_overflowT = 1'b1;
    @(negedge clk);
    m_overflowT = 1'b0;
    @(negedge clk);
    tests++;
    if (err_overflow !== 1'b1) begin
      failed++;
      $display("FAIL overflow_set: got %b, required 1", err_overflow);
    end
    err_clr     = 1'b1;
    m_overflowR = 1'b1;
    @(negedge clk);
    err_clr     = 1'b0;
    m_overflowR = 1'b0;
    tests++;
    if (err_overflow !== 1'b1) begin
      failed++;
      $display("FAIL overflow_set_wins: got %b, required 1", err_overflow);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (err_overflow !== 1'b0) begin
      failed++;
      $display("FAIL overflow_clear: got %b, required 0", err_overflow);
    end
  endtask

  task automatic test_async_reset();
    bit got;
    got = 1'b0;
    ins_delay = 30;
    req_data[2*DATAW +: DATAW] = 16'h1234;
    req_last[2]  = 1'b0;
    req_valid[2] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready[2]) begin
        got = 1'b1;
        break;
      end
    end
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (!got || busy !== 1'b1 || m_tData !== 16'h1234) begin
      failed++;
      $display("FAIL async_pre: got ready_seen=%b busy=%b tdata=%h, required 1 1 1234", got, busy, m_tData);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || m_tData !== '0 || grant_id !== '0 || m_requestInsert !== 1'b0) begin
      failed++;
      $display("FAIL async_reset: got busy=%b tdata=%h grant=%0d ins=%b, required all 0",
               busy, m_tData, grant_id, m_requestInsert);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ins_delay = 0;
    grant_log.delete();
    send_pkt(2, 2, 16'h2300, -1, 0);
    wait_idle("async_resend");
    tests++;
    if (grant_log.size() != 1 || grant_log[0] != 2) begin
      failed++;
      $display("FAIL async_resend_grant: got %p, required '{2}", grant_log);
    end
  endtask

`ifdef SPI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    int cyc;
    got = 1'b0;
    cyc = 0;
    master_en = 1'b0;
    req_data[1*DATAW +: DATAW] = 16'h7777;
    req_last[1]  = 1'b1;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        got = 1'b1;
        break;
      end
    end
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (err_timeout) begin
        cyc = c;
        break;
      end
    end
    tests++;
    if (!got || cyc != 64 || busy !== 1'b0) begin
      failed++;
      $display("FAIL timeout_fire: got cycles=%0d busy=%b, required cycles=64 busy=0", cyc, busy);
    end
    master_en = 1'b1;
    err_clr   = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    tests++;
    if (err_timeout !== 1'b0) begin
      failed++;
      $display("FAIL timeout_clear: got %b, required 0", err_timeout);
    end
    grant_log.delete();
    fork
      send_pkt(0, 1, 16'h0D00, -1, 0);
      send_pkt(2, 1, 16'h2D00, -1, 0);
    join
    wait_idle("timeout_next");
    tests++;
    if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 0) begin
      failed++;
      $display("FAIL timeout_next_grant: got %p, required '{2, 0}", grant_log);
    end
  endtask
`endif

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    m_doneInsert = 1'b0;
    m_rData     = '0;
    mdl_rx      = 1'b0;
    spur_rx     = 1'b0;
    m_overflowT = 1'b0;
    m_overflowR = 1'b0;
    err_clr     = 1'b0;

    test_reset();
    test_single_packet();
    test_round_robin();
    test_slow_load();
    test_bubble();
    test_spurious();
    test_overflow();
    test_async_reset();
`ifdef SPI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule
